// File: rtl/led_nios2_qsys_div_cell_if.sv
// Handshake and operand bundle between the A-stage and the sequential divide cell.
interface led_nios2_qsys_div_cell_if #(
    parameter int DATA_W = 32
);
    logic              A_div_start;
    logic [DATA_W-1:0] A_div_src1;
    logic [DATA_W-1:0] A_div_src2;
    logic              A_div_signed;
    logic              A_div_rem;
    logic              A_div_busy;
    logic              A_div_done;
    logic [DATA_W-1:0] A_div_cell_result;

    modport master (
        output A_div_start, A_div_src1, A_div_src2, A_div_signed, A_div_rem,
        input  A_div_busy, A_div_done, A_div_cell_result
    );

    modport slave (
        input  A_div_start, A_div_src1, A_div_src2, A_div_signed, A_div_rem,
        output A_div_busy, A_div_done, A_div_cell_result
    );
endinterface

// File: rtl/led_nios2_qsys_div_cell.sv
// Radix-2 restoring 32-bit divider, one quotient bit per clock, quotient or remainder out.
// Signed operands are supported only when LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN is defined.
module led_nios2_qsys_div_cell #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input logic                      clk,
    input logic                      reset,
    led_nios2_qsys_div_cell_if.slave div
);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [DATA_W-1:0] dvd_q, dvsr_q, result_q;
    logic [DATA_W:0]   prem_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rem_sel_q, done_q;

    logic [DATA_W+1:0] shl_rem, trial;
    logic              trial_ok;
    logic [DATA_W-1:0] dvd_init, dvsr_init, quo_fix, rem_fix;

`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
    logic signed_q, sign_q_q, sign_r_q;
    logic sign_q_init, sign_r_init;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        return (v < 0) ? negate(v) : v;
    endfunction
`else
    logic unused_signed;
    assign unused_signed = div.A_div_signed;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (div.A_div_start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (cnt_q == CNT_W'(DATA_W - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shifted partial remainder carries a spare top bit so the trial sign is exact.
    assign shl_rem  = {prem_q, dvd_q[DATA_W-1]};
    assign trial    = shl_rem - {2'b00, dvsr_q};
    assign trial_ok = ~trial[DATA_W+1];

    always_comb begin
        dvd_init  = src1_q;
        dvsr_init = src2_q;
        quo_fix   = dvd_q;
        rem_fix   = prem_q[DATA_W-1:0];
`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
        // A zero divisor keeps the all-ones quotient unsigned so it is not negated.
        sign_q_init = signed_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]) & (|src2_q);
        sign_r_init = signed_q & src1_q[DATA_W-1];
        if (signed_q) begin
            dvd_init  = magnitude(src1_q);
            dvsr_init = magnitude(src2_q);
        end
        if (sign_q_q) quo_fix = negate(dvd_q);
        if (sign_r_q) rem_fix = negate(prem_q[DATA_W-1:0]);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src1_q    <= '0;
            src2_q    <= '0;
            dvd_q     <= '0;
            dvsr_q    <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
            signed_q  <= 1'b0;
            sign_q_q  <= 1'b0;
            sign_r_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (div.A_div_start) begin
                        src1_q    <= div.A_div_src1;
                        src2_q    <= div.A_div_src2;
                        rem_sel_q <= div.A_div_rem;
`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
                        signed_q  <= div.A_div_signed;
`endif
                    end
                end
                PREP: begin
                    dvd_q  <= dvd_init;
                    dvsr_q <= dvsr_init;
                    prem_q <= '0;
                    cnt_q  <= '0;
`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
                    sign_q_q <= sign_q_init;
                    sign_r_q <= sign_r_init;
`endif
                end
                ITER: begin
                    prem_q <= trial_ok ? trial[DATA_W:0] : shl_rem[DATA_W:0];
                    dvd_q  <= {dvd_q[DATA_W-2:0], trial_ok};
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    result_q <= rem_sel_q ? rem_fix : quo_fix;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign div.A_div_busy        = (state != IDLE);
    assign div.A_div_done        = done_q;
    assign div.A_div_cell_result = result_q;

endmodule

// File: tb/tb_led_nios2_qsys_div_cell.sv
// Scoreboard bench for led_nios2_qsys_div_cell: expected results queued at start, compared at done.
module tb_led_nios2_qsys_div_cell;

`ifdef LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    led_nios2_qsys_div_cell_if #(.DATA_W(32)) div_if ();

    led_nios2_qsys_div_cell #(.DATA_W(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div_if.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn, input logic rm);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'h0) return rm ? a : 32'hFFFF_FFFF;
        if (sgn && SIGNED_EN) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
            return rm ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rm ? (a % b) : (a / b);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic sgn, input logic rm);
        div_if.A_div_start  = 1'b1;
        div_if.A_div_src1   = a;
        div_if.A_div_src2   = b;
        div_if.A_div_signed = sgn;
        div_if.A_div_rem    = rm;
        exp_q.push_back(model(a, b, sgn, rm));
        @(negedge clk);
        div_if.A_div_start = 1'b0;
        check("busy_after_start", {31'b0, div_if.A_div_busy}, 32'd1);
    endtask

    // Counts edges after the accepting edge until done; optionally pulses a stray start.
    task automatic wait_done(input string tag, input int stray_at);
        int          lat;
        logic [31:0] exp;
        lat = 0;
        while (!div_if.A_div_done && lat < 200) begin
            div_if.A_div_start = (lat == stray_at);
            if (lat == stray_at) begin
                div_if.A_div_src1 = 32'hDEAD_BEEF;
                div_if.A_div_src2 = 32'h3;
                div_if.A_div_rem  = ~div_if.A_div_rem;
            end
            @(negedge clk);
            lat++;
        end
        div_if.A_div_start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd34);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, div_if.A_div_cell_result, exp);
        end
        check({tag, "_busy_in_done"}, {31'b0, div_if.A_div_busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, held;
        logic        seen;

        reset = 1'b1;
        div_if.A_div_start  = 1'b0;
        div_if.A_div_src1   = '0;
        div_if.A_div_src2   = '0;
        div_if.A_div_signed = 1'b0;
        div_if.A_div_rem    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, div_if.A_div_busy}, 32'd0);
        check("reset_done", {31'b0, div_if.A_div_done}, 32'd0);
        check("reset_result", div_if.A_div_cell_result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        start_op(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done("udiv_100_7_q", -1);
        held = div_if.A_div_cell_result;
        @(negedge clk);
        check("result_held", div_if.A_div_cell_result, held);
        check("done_one_cycle", {31'b0, div_if.A_div_done}, 32'd0);

        start_op(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done("udiv_100_7_r", -1);

        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        wait_done("sdiv_m7_2_q", -1);
        start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        wait_done("sdiv_m7_2_r", -1);

        start_op(32'h1234_5678, 32'h0, 1'b0, 1'b0);
        wait_done("divzero_q", -1);
        start_op(32'h1234_5678, 32'h0, 1'b0, 1'b1);
        wait_done("divzero_r", -1);
        start_op(32'h8000_0001, 32'h0, 1'b1, 1'b0);
        wait_done("divzero_neg_q", -1);
        start_op(32'h8000_0001, 32'h0, 1'b1, 1'b1);
        wait_done("divzero_neg_r", -1);

        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done("overflow_q", -1);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        wait_done("overflow_r", -1);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            start_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_done("random", -1);
        end

        start_op(32'd1000, 32'd9, 1'b0, 1'b0);
        wait_done("stray_start", 10);
        @(negedge clk);
        check("stray_not_latched", {31'b0, div_if.A_div_busy}, 32'd0);

        // Second start issued in the first done cycle.
        start_op(32'd5000, 32'd13, 1'b0, 1'b0);
        wait_done("b2b_first", -1);
        start_op(32'd5000, 32'd13, 1'b0, 1'b1);
        wait_done("b2b_second", -1);

        @(negedge clk);
        start_op(32'hCAFE_F00D, 32'd77, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'b0, div_if.A_div_busy}, 32'd0);
        check("abort_done", {31'b0, div_if.A_div_done}, 32'd0);
        check("abort_result", div_if.A_div_cell_result, 32'd0);
        if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (div_if.A_div_done) seen = 1'b1;
        end
        check("no_done_after_abort", {31'b0, seen}, 32'd0);

        start_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0);
        wait_done("after_reset", -1);
        check("after_reset_const", div_if.A_div_cell_result, 32'h0FFF_FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/led_nios2_qsys_div_cell.md
# led_nios2_qsys_div_cell

Sequential 32-bit integer divider for the Nios II/f custom arithmetic path: the inverse companion of the multiply cell. It accepts a dividend/divisor pair on a start pulse and iterates one radix-2 restoring step per clock. It returns either quotient or remainder with a one-cycle done strobe. It sits beside the multiply cell in the A-stage and is stalled by the CPU pipeline while busy.

## Interface
Parameters:
- DATA_W, 32, operand and result width; only 32 is supported.
- CNT_W, 5, iteration counter width; must be log2(DATA_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- A_div_start  input  1  single-cycle request; sampled only when idle.
- A_div_src1  input  32  dividend; sampled with start.
- A_div_src2  input  32  divisor; sampled with start.
- A_div_signed  input  1  1 = two's-complement operands; sampled with start.
- A_div_rem  input  1  1 = return remainder, 0 = return quotient; sampled with start.
- A_div_busy  output  1  high from the cycle after an accepted start until done.
- A_div_done  output  1  one-cycle strobe; result valid in this cycle.
- A_div_cell_result  output  32  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE:
  - start=1 latches the operands, signed and rem flags.
  - Next state is PREP.
- PREP:
  - If signed, take the magnitudes of both operands and record sign_q = s1^s2 and sign_r = s1.
  - Load the working dividend, clear the 33-bit partial remainder and clear the counter.
  - Next state is ITER.
- ITER, one step per edge:
  - Shift {rem, dvd} left 1.
  - Trial subtract divisor from the upper 33 bits.
  - If the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - After 32 steps, next state is FIX.
- FIX:
  - Negate the quotient if sign_q is set.
  - Negate the remainder if sign_r is set.
  - Select the quotient or remainder into A_div_cell_result, assert done, and go to IDLE.
- Remainder sign follows the dividend (truncating division), matching the Nios II div/divu definition.
- Divide by zero (src2 = 0), in either mode:
  - Quotient is 0xFFFFFFFF.
  - Remainder is the original src1.
  - There is no trap and the latency is the normal latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - Quotient is 0x80000000.
  - Remainder is 0.
- A start while busy is ignored: no latch, no effect on the operation in flight.

## Timing
- Reset values: A_div_busy=0, A_div_done=0, A_div_cell_result=0, state=IDLE, counter=0.
- If start is sampled at edge E0:
  - PREP occupies E0 to E1.
  - ITER runs on edges E2 through E33.
  - FIX registers the result at edge E34.
- Latency: done is high in the cycle following E34, which is 34 cycles after the start cycle.
- Busy:
  - High from the cycle after E0 through the cycle before done.
  - Low in the done cycle.
- Back-to-back:
  - State is IDLE during the done cycle, so a start in that same cycle is accepted.
  - Throughput is therefore one divide per 35 cycles.
- Result stability:
  - A_div_cell_result changes only at the FIX edge or on reset.
  - It is stable for the whole done cycle and afterwards.
- Reset mid-operation:
  - Reset asserted in any state forces IDLE immediately and clears all outputs.
  - No done is produced for the aborted operation.

## Configuration
- Macro: LED_NIOS2_QSYS_DIV_CELL_SIGNED_EN.
- Defined:
  - Signed support is present: magnitude conversion in PREP and sign correction in FIX.
  - A_div_signed is honoured.
- Undefined:
  - Unsigned-only datapath; A_div_signed is ignored and treated as 0.
  - Negation logic is removed and latency is unchanged (FIX is still one cycle).
  - Divide-by-zero results are unchanged.

## Test plan
- Unsigned basic: src1=100, src2=7, signed=0.
  - rem=0: result 14 (0x0000000E), done exactly 34 cycles after start.
  - rem=1: result 2.
- Signed truncation (with the macro defined): src1=0xFFFFFFF9 (-7), src2=2, signed=1.
  - Quotient: 0xFFFFFFFD (-3).
  - Remainder: 0xFFFFFFFF (-1).
- Corner operands:
  - Divide by zero, src1=0x12345678, src2=0: quotient 0xFFFFFFFF, remainder 0x12345678.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Handshake:
  - Start pulsed again at cycle 10 of an operation: ignored, first result correct.
  - Start in the done cycle: accepted, second done 35 cycles after the first.
- Reset mid-operation:
  - Assert reset at iteration 15: busy, done and result become 0 immediately; no done follows.
  - A fresh 0xFFFFFFFF / 0x10 after reset returns 0x0FFFFFFF.
